chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Multi-cycle N-bit adder/subtractor. Processes the operands W bits per cycle, least significant chunk first, through one W-bit carry-chain slice.
- Carry is registered between chunks, so wide adds (128+ bits) run at a short critical path.
- Valid/ready handshakes on input and output. Supports add and subtract modes. Produces carry-out and signed-overflow flags.
- Sits in the arithmetic datapath as the successor of the flat combinational ripple-carry adder.

Parameters:
- N, 128, total operand width in bits. Must be a multiple of W.
- W, 32, chunk width added per cycle. Range 1..N.
- K (localparam), N/W, number of chunks. A counter of width max(1, clog2(K)) indexes the current chunk.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block can accept an operation
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  carry-in (add) or borrow-in (subtract)
- sub  in  1  0: s=a+b+cin; 1: s=a-b-cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  N  sum/difference, modulo 2^N
- cout  out  1  raw carry out of bit N-1. In subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over everything:
  - state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0
  - chunk counter=0, carry register=0
  - any in-flight operation is discarded; no partial result is ever presented.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept, on in_valid && in_ready in IDLE:
  - latch a into an A register.
  - latch the effective B, b_eff = sub ? ~b : b, into a B register.
  - carry register <= cin ^ sub.
  - latch a[N-1], b_eff[N-1] for the overflow check.
  - counter <= 0; go to RUN.
  - in_valid in any other state is ignored (no sampling).
- RUN, each cycle, with k = counter:
  - {c, s[k*W +: W]} <= A[k*W +: W] + B[k*W +: W] + carry; carry <= c.
  - if k == K-1: cout <= c; ovf <= (a_msb == b_msb) && (new s[N-1] != a_msb); go to DONE.
  - otherwise counter <= k+1.
- Timing:
  - Accept at edge T gives out_valid=1 after edge T+K. Latency is K+1 cycles from the accept cycle. For N=128, W=32: out_valid rises 4 cycles after the accept edge.
  - K=1 (W=N) is legal: a single RUN cycle.
- DONE:
  - s, cout and ovf are held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: go to IDLE. in_ready=1 from the next cycle.
  - No same-cycle output-to-input bypass. Maximum throughput is one operation per K+2 cycles.
- s bits of chunks not yet computed hold stale values during RUN. They are don't-care because out_valid=0.
- Wrap-around: all results are modulo 2^N. Carry/borrow is reported only via cout.
- Simultaneous reset and handshake: reset wins; the operation is not accepted.

Test Plan:
- N=128, W=32, add. a=all-ones, b=1, cin=0 → s=0, cout=1, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Carry across every chunk boundary. a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=0, cin=1 → s=0x0000_0001_0000_0000_0000_0000_0000_0000, cout=0.
- Subtract with borrow. sub=1, a=5, b=7, cin=0 → s=2^128-2, cout=0, ovf=0.
- Subtract with borrow-in. sub=1, a=10, b=3, cin=1 → s=6, cout=1.
- Signed overflow, add. a=0x7FFF…F, b=1, cin=0 → s=0x8000…0, ovf=1, cout=0.
- Back-pressure. Hold out_ready=0 for 3 cycles in DONE, toggling in_valid with new operands → s/cout/ovf unchanged, in_ready=0, new operands not taken. Raise out_ready → in_ready=1 next cycle, next operation computes correctly.
- Reset mid-operation. rst_n=0 for 1 cycle at the 2nd RUN cycle → next cycle: in_ready=1, out_valid=0, s=0, cout=0, ovf=0. A following operation a=3, b=4, cin=0 → s=7.

Source files
------------

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder
// Description : Multi-cycle N-bit adder/subtractor. Operands are processed
//               W bits per cycle, least significant chunk first, through a
//               single W-bit carry-chain slice with a registered carry between
//               chunks. Valid/ready handshakes on input and output.
// Ports       : clk       - rising-edge clock
//               rst_n     - synchronous active-low reset
//               in_valid  - operands/mode valid
//               in_ready  - block can accept an operation (IDLE)
//               a, b      - N-bit operands
//               cin       - carry-in (add) / borrow-in (subtract)
//               sub       - 0: s = a+b+cin, 1: s = a-b-cin
//               out_valid - result valid (DONE)
//               out_ready - consumer accepts result
//               s         - sum/difference modulo 2^N
//               cout      - raw carry out of bit N-1 (subtract: 1 = no borrow)
//               ovf       - two's-complement signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
    parameter int N = 128,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_carry;
    logic            r_a_msb;
    logic            r_b_msb;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_s;
    logic            r_cout;
    logic            r_ovf;

    logic [N-1:0]    w_b_eff;
    logic [W-1:0]    w_a_chunk;
    logic [W-1:0]    w_b_chunk;
    logic [W:0]      w_sum;
    logic            w_last;

    // Subtraction is a + ~b + 1 - borrow_in, so the inverted operand is
    // stored and the initial carry becomes cin ^ sub.
    assign w_b_eff = sub ? ~b : b;
    assign w_last  = (r_cnt == CW'(K - 1));

    // Select the current chunk with constant slices so no variable
    // part-select arithmetic appears on the operand path.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < K; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_chunk = r_a[k*W +: W];
                w_b_chunk = r_b[k*W +: W];
            end
        end
    end

    assign w_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{W{1'b0}}, r_carry};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= cin ^ sub;
                        r_a_msb <= a[N-1];
                        r_b_msb <= w_b_eff[N-1];
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < K; k++) begin
                        if (r_cnt == CW'(k)) begin
                            r_s[k*W +: W] <= w_sum[W-1:0];
                        end
                    end
                    r_carry <= w_sum[W];
                    if (w_last) begin
                        // On the final chunk, w_sum[W-1] is the new s[N-1].
                        r_cout <= w_sum[W];
                        r_ovf  <= (r_a_msb == r_b_msb) && (w_sum[W-1] != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_serial_adder
// Description : Self-checking bench for chunked_serial_adder: directed table,
//               hand-written handshake/reset sequences and random operations
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_serial_adder;

    localparam int N = 128;
    localparam int W = 32;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic         sb;
        logic         ci;
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic [N-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain unbounded-integer arithmetic on wider vectors.
    function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                  input logic mci, input logic msb,
                                  output logic [N-1:0] rs, output logic rc, output logic ro);
        logic [N:0]   u;
        logic [N+1:0] sg;
        logic [N+1:0] sa;
        logic [N+1:0] sbv;
        logic [N+1:0] c2;
        sa  = {{2{ma[N-1]}}, ma};
        sbv = {{2{mb[N-1]}}, mb};
        c2  = {{(N+1){1'b0}}, mci};
        if (msb) begin
            u  = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mci};
            rc = ~u[N];          // no borrow
            sg = sa - sbv - c2;
        end else begin
            u  = {1'b0, ma} + {1'b0, mb} + {{N{1'b0}}, mci};
            rc = u[N];
            sg = sa + sbv + c2;
        end
        rs = u[N-1:0];
        ro = (sg[N+1:N-1] != 3'b000) && (sg[N+1:N-1] != 3'b111);
    endfunction

    function automatic logic [N-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one operation from IDLE and wait for out_valid; leaves DUT in DONE.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic tci, input logic tsb,
                          output logic [N-1:0] rs, output logic rc, output logic ro);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_op", {{(N-1){1'b0}}, in_ready}, 1);
        a        = ta;
        b        = tb_v;
        cin      = tci;
        sub      = tsb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", N'(lat), N'(K));
        rs = s;
        rc = cout;
        ro = ovf;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_release", {{(N-1){1'b0}}, in_ready}, 1);
        chk("out_valid_after_release", {{(N-1){1'b0}}, out_valid}, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  {{(N-1){1'b0}}, in_ready},  1);
        chk({tag, "_out_valid"}, {{(N-1){1'b0}}, out_valid}, 0);
        chk({tag, "_s"},         s, '0);
        chk({tag, "_cout"},      {{(N-1){1'b0}}, cout}, 0);
        chk({tag, "_ovf"},       {{(N-1){1'b0}}, ovf},  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rs, es, hs;
        logic         rc, ro, ec, eo, hc, ho;
        int           d;

        tbl[0] = '{1'b0, 1'b0, {N{1'b1}}, 128'd1, 128'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd0,
                   128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 128'd5, 128'd7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 128'd10, 128'd3, 128'd6, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
                   128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1,
                   128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i].va, tbl[i].vb, tbl[i].ci, tbl[i].sb, rs, rc, ro);
            chk($sformatf("tbl%0d_s", i),    rs, tbl[i].es);
            chk($sformatf("tbl%0d_cout", i), {{(N-1){1'b0}}, rc}, {{(N-1){1'b0}}, tbl[i].ec});
            chk($sformatf("tbl%0d_ovf", i),  {{(N-1){1'b0}}, ro}, {{(N-1){1'b0}}, tbl[i].eo});
            finish_op();
        end

        // Back-pressure: outputs hold, new operands ignored
        model(128'd123456789, 128'd987654321, 1'b1, 1'b0, es, ec, eo);
        run_op(128'd123456789, 128'd987654321, 1'b1, 1'b0, hs, hc, ho);
        chk("bp_s_initial", hs, es);
        for (int i = 0; i < 3; i++) begin
            a        = rnd128();
            b        = rnd128();
            cin      = 1'b1;
            sub      = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_s_hold",    s, es);
            chk("bp_cout_hold", {{(N-1){1'b0}}, cout}, {{(N-1){1'b0}}, ec});
            chk("bp_ovf_hold",  {{(N-1){1'b0}}, ovf},  {{(N-1){1'b0}}, eo});
            chk("bp_in_ready",  {{(N-1){1'b0}}, in_ready},  0);
            chk("bp_out_valid", {{(N-1){1'b0}}, out_valid}, 1);
        end
        in_valid = 1'b0;
        finish_op();
        model(128'd1000, 128'd1, 1'b0, 1'b1, es, ec, eo);
        run_op(128'd1000, 128'd1, 1'b0, 1'b1, rs, rc, ro);
        chk("bp_next_s", rs, es);
        chk("bp_next_cout", {{(N-1){1'b0}}, rc}, {{(N-1){1'b0}}, ec});
        finish_op();

        // Reset together with a handshake: not accepted
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a = 128'd1; b = 128'd1; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk_reset_state("rst_hs");
        repeat (K + 2) @(negedge clk);
        chk("rst_hs_no_result", {{(N-1){1'b0}}, out_valid}, 0);

        // Reset during the second RUN cycle
        a = 128'd9; b = 128'd9; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);          // accepted
        in_valid = 1'b0;
        @(negedge clk);          // first RUN chunk done
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_state("rst_mid");
        run_op(128'd3, 128'd4, 1'b0, 1'b0, rs, rc, ro);
        chk("rst_mid_next_s", rs, 128'd7);
        finish_op();

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra, rb;
            logic         rci, rsb;
            ra  = rnd128();
            rb  = rnd128();
            if (i % 8 == 1) rb = ~ra;
            if (i % 8 == 2) rb = ra;
            rci = 1'($urandom);
            rsb = 1'($urandom);
            model(ra, rb, rci, rsb, es, ec, eo);
            run_op(ra, rb, rci, rsb, rs, rc, ro);
            d = int'($urandom_range(0, 3));
            repeat (d) @(negedge clk);
            chk($sformatf("rnd%0d_s", i),    s, es);
            chk($sformatf("rnd%0d_cout", i), {{(N-1){1'b0}}, cout}, {{(N-1){1'b0}}, ec});
            chk($sformatf("rnd%0d_ovf", i),  {{(N-1){1'b0}}, ovf},  {{(N-1){1'b0}}, eo});
            finish_op();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
